// File: rtl/rr_selector_arbiter_if.sv
// Request/data/grant bundle shared between the four requesters and the
// round-robin output arbiter.
interface rr_selector_arbiter_if #(
    parameter int unsigned DW = 2
);
    logic [3:0]      req;
    logic [4*DW-1:0] data;
    logic [3:0]      grant;
    logic [1:0]      sel;
    logic [DW-1:0]   dout;
    logic            dout_valid;

    modport master (
        output req, data,
        input  grant, sel, dout, dout_valid
    );

    modport slave (
        input  req, data,
        output grant, sel, dout, dout_valid
    );
endinterface

// File: rtl/rr_selector_arbiter.sv
// Round-robin arbiter sharing one registered DW-bit output channel among four
// requesters; a grant ends on request drop or after HOLD_CYCLES captured words.
module rr_selector_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned DW          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_selector_arbiter_if.slave  bus
);
    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;
    logic [DW-1:0]    lane;

    // First requester at or after ptr, wrapping modulo four.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Lane mux driven by the registered select.
    always_comb begin
        lane = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.sel == 2'(i)) lane = bus.data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            cnt            <= '0;
            bus.grant      <= '0;
            bus.sel        <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.dout_valid <= 1'b0;
                    if (|bus.req) begin
                        bus.grant <= 4'b0001 << win;
                        bus.sel   <= win;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[bus.sel]) begin
                        bus.dout_valid <= 1'b0;
                        bus.grant      <= '0;
                        ptr            <= bus.sel + 2'd1;
                        state          <= IDLE;
                    end else begin
                        bus.dout       <= lane;
                        bus.dout_valid <= 1'b1;
                        // Pointer moves only on release so a held request is served within three grants.
                        if (cnt == CNT_LAST) begin
                            bus.grant <= '0;
                            ptr       <= bus.sel + 2'd1;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_selector_arbiter.sv
// Directed bench for rr_selector_arbiter: one instance with a four-word budget,
// one with a single-word budget for the sparse pointer-wrap case.
module tb_rr_selector_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rr_selector_arbiter_if #(.DW(2)) bus_a ();
    rr_selector_arbiter_if #(.DW(2)) bus_b ();

    rr_selector_arbiter #(.HOLD_CYCLES(4), .DW(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    rr_selector_arbiter #(.HOLD_CYCLES(1), .DW(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input int i);
        return 4'b0001 << i;
    endfunction

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus_a.req  = 4'b1111;
        bus_a.data = 8'b11_10_01_00;
        bus_b.req  = 4'b0000;
        bus_b.data = 8'b10_00_00_01;

        // Reset held for two edges with all requests up.
        step();
        step();
        check("rst_grant", 32'(bus_a.grant), 32'(4'b0000));
        check("rst_sel",   32'(bus_a.sel),   32'(2'd0));
        check("rst_dout",  32'(bus_a.dout),  32'(2'b00));
        check("rst_valid", 32'(bus_a.dout_valid), 32'(1'b0));

        // Full contention: grants 0,1,2,3,0 with four words of the lane index each.
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            step();
            check("cont_grant", 32'(bus_a.grant), 32'(onehot(g % 4)));
            check("cont_sel",   32'(bus_a.sel),   32'(g % 4));
            check("cont_gap_valid", 32'(bus_a.dout_valid), 32'(1'b0));
            for (int w = 0; w < 4; w++) begin
                step();
                check("cont_dout",  32'(bus_a.dout), 32'(g % 4));
                check("cont_valid", 32'(bus_a.dout_valid), 32'(1'b1));
                check("cont_hold",  32'(bus_a.grant), (w == 3) ? 32'(0) : 32'(onehot(g % 4)));
            end
        end

        // Single requester 2 with lane value 10, then immediate re-grant.
        bus_a.req  = 4'b0100;
        bus_a.data = 8'b00_10_00_00;
        step();
        check("single_grant", 32'(bus_a.grant), 32'(4'b0100));
        for (int w = 0; w < 4; w++) begin
            step();
            check("single_dout",  32'(bus_a.dout), 32'(2'b10));
            check("single_valid", 32'(bus_a.dout_valid), 32'(1'b1));
        end
        check("single_release", 32'(bus_a.grant), 32'(4'b0000));
        step();
        check("single_regrant", 32'(bus_a.grant), 32'(4'b0100));
        check("single_gap_valid", 32'(bus_a.dout_valid), 32'(1'b0));

        // Drop before any capture: no word, dout holds its last value.
        bus_a.req = 4'b0000;
        step();
        check("drop0_grant", 32'(bus_a.grant), 32'(4'b0000));
        check("drop0_valid", 32'(bus_a.dout_valid), 32'(1'b0));
        check("drop0_dout",  32'(bus_a.dout), 32'(2'b10));

        // Early drop by requester 1 after two words; others pending release first.
        bus_a.req  = 4'b0010;
        bus_a.data = 8'b00_00_01_00;
        step();
        check("early_grant", 32'(bus_a.grant), 32'(4'b0010));
        for (int w = 0; w < 2; w++) begin
            step();
            check("early_dout",  32'(bus_a.dout), 32'(2'b01));
            check("early_valid", 32'(bus_a.dout_valid), 32'(1'b1));
        end
        bus_a.req = 4'b1101;
        step();
        check("early_release", 32'(bus_a.grant), 32'(4'b0000));
        check("early_novalid", 32'(bus_a.dout_valid), 32'(1'b0));
        check("early_dout_hold", 32'(bus_a.dout), 32'(2'b01));
        step();
        check("early_next_grant", 32'(bus_a.grant), 32'(4'b0100));
        check("early_next_sel",   32'(bus_a.sel),   32'(2'd2));

        // Reset on the third capture edge of requester 2's grant.
        bus_a.data = 8'b11_10_01_00;
        step();
        step();
        check("midrst_pre_dout",  32'(bus_a.dout), 32'(2'd2));
        rst = 1'b1;
        step();
        check("midrst_grant", 32'(bus_a.grant), 32'(4'b0000));
        check("midrst_sel",   32'(bus_a.sel),   32'(2'd0));
        check("midrst_dout",  32'(bus_a.dout),  32'(2'b00));
        check("midrst_valid", 32'(bus_a.dout_valid), 32'(1'b0));
        rst       = 1'b0;
        bus_a.req = 4'b1111;
        step();
        check("midrst_next_grant", 32'(bus_a.grant), 32'(4'b0001));

        // Single-word budget, requesters 0 and 3 alternate.
        bus_a.req = 4'b0000;
        bus_b.req = 4'b1001;
        for (int g = 0; g < 4; g++) begin
            step();
            check("wrap_grant", 32'(bus_b.grant), (g % 2 == 0) ? 32'(4'b0001) : 32'(4'b1000));
            step();
            check("wrap_release", 32'(bus_b.grant), 32'(4'b0000));
            check("wrap_valid",   32'(bus_b.dout_valid), 32'(1'b1));
            check("wrap_dout",    32'(bus_b.dout), (g % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
